// File: rtl/decode_pipe.sv
// decode_pipe: single-stage instruction decode with 8-entry register file, load-use stall and halt control.
module decode_pipe #(
    parameter int DATA_W = 32,
    parameter bit BYPASS = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_pc,
    input  logic [15:0]       in_pc_plus1,
    input  logic [15:0]       in_inst,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [2:0]        wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_pc,
    output logic [15:0]       out_inst,
    output logic [DATA_W-1:0] out_rd1,
    output logic [DATA_W-1:0] out_rd2,
    output logic [3:0]        out_alu_ctrl,
    output logic              out_jb,
    output logic              out_imm_a,
    output logic              out_rs_or_imm,
    output logic              out_mem_wr,
    output logic              out_mem_rd,
    output logic              out_wr_en,
    output logic              out_halt,
    output logic [2:0]        out_wr_reg,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef enum logic {RUN, HALTED} state_t;
    state_t state, state_nx;
    logic [DATA_W-1:0] rf [8];
    logic [DATA_W-1:0] rd1, rd2;
    logic [3:0] opcode, alu_ctrl;
    logic [2:0] src1, src2;
    logic dec_halt, hazard, accept;

    assign opcode   = in_inst[15:12];
    assign src1     = in_inst[14] ? in_inst[11:9] : in_inst[5:3];
    assign src2     = in_inst[8:6];
    assign dec_halt = opcode == 4'b0000;
    assign rd1      = (BYPASS && wb_en && wb_reg == src1) ? wb_data : rf[src1];
    assign rd2      = (BYPASS && wb_en && wb_reg == src2) ? wb_data : rf[src2];
    assign alu_ctrl = opcode[3:2] == 2'b11 ? {2'b00, opcode[1:0]} :
                      opcode == 4'b1011   ? (in_inst[2:0] == 3'b000 ? 4'b1000 : {1'b0, in_inst[2:0]}) :
                      opcode == 4'b1010   ? {1'b1, in_inst[2:0]} : 4'b1111;
    // load-use: the load in the output register has not produced its data yet
    assign hazard   = out_valid & out_mem_rd & out_wr_en & (out_wr_reg == src1 | out_wr_reg == src2);
    assign halted   = state == HALTED;
    assign in_ready = !rst & !flush & !halted & !hazard & (!out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_nx = state;
        if (state == RUN && accept && dec_halt)
            state_nx = HALTED;
        else if (state == HALTED && flush && out_valid && out_halt)
            state_nx = RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++)
                rf[i] <= '0;
        end else if (wb_en) begin
            rf[wb_reg] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (in_valid && hazard && !flush && !(&stall_cnt))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_inst      <= '0;
            out_rd1       <= '0;
            out_rd2       <= '0;
            out_alu_ctrl  <= '0;
            out_jb        <= 1'b0;
            out_imm_a     <= 1'b0;
            out_rs_or_imm <= 1'b0;
            out_mem_wr    <= 1'b0;
            out_mem_rd    <= 1'b0;
            out_wr_en     <= 1'b0;
            out_halt      <= 1'b0;
            out_wr_reg    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_pc        <= dec_halt ? in_pc : in_pc_plus1;
            out_inst      <= in_inst;
            out_rd1       <= rd1;
            out_rd2       <= rd2;
            out_alu_ctrl  <= alu_ctrl;
            out_jb        <= opcode == 4'b0100 || opcode == 4'b0010;
            out_imm_a     <= opcode == 4'b1000 || opcode == 4'b0111;
            out_rs_or_imm <= in_inst[13];
            out_mem_wr    <= opcode == 4'b0111;
            out_mem_rd    <= opcode == 4'b1000;
            out_wr_en     <= in_inst[15];
            out_halt      <= dec_halt;
            out_wr_reg    <= in_inst[11:9];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter DATA_W, default 32, register-file and operand data width.
REQ-002 Parameter BYPASS, default 1, 1 = same-cycle writeback-to-read forwarding, 0 = none.
REQ-003 Parameter CNT_W, default 16, width of the stall counter.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid / in_ready  input / output  1 / 1  fetch-side handshake; transfer when both are high.
REQ-007 in_pc, in_pc_plus1, in_inst  input  16 each  fetched PC, PC+1, instruction.
REQ-008 flush  input  1  squash request from branch resolution.
REQ-009 wb_en, wb_reg, wb_data  input  1, 3, DATA_W  register-file write port.
REQ-010 out_valid / out_ready  output / input  1 / 1  execute-side handshake.
REQ-011 out_pc, out_inst  output  16 each  registered next PC and instruction.
REQ-012 out_rd1, out_rd2  output  DATA_W each  registered operand data.
REQ-013 out_alu_ctrl  output  4  registered ALU control.
REQ-014 out_jb, out_imm_a, out_rs_or_imm, out_mem_wr, out_mem_rd, out_wr_en, out_halt  output  1 each  registered control flags.
REQ-015 out_wr_reg  output  3  registered destination register.
REQ-016 halted  output  1  high in HALTED state.
REQ-017 stall_cnt  output  CNT_W  count of hazard-stall cycles.

Function
REQ-018 The decode fields SHALL be: opcode = inst[15:12]; src1 = inst[14] ? inst[11:9] : inst[5:3]; src2 = inst[8:6]; wr_reg = inst[11:9]; wr_en = inst[15]; rs_or_imm = inst[13].
REQ-019 The control flags SHALL be: halt = opcode 0000; jb = opcode 0100 or 0010; mem_rd = 1000; mem_wr = 0111; imm_a = 1000 or 0111.
REQ-020 alu_ctrl SHALL be: 1100->0000, 1101->0001, 1110->0010, 1111->0011, 1011->{0,inst[2:0]} (1000 if inst[2:0]=0), 1010->{1,inst[2:0]}, other->1111.
REQ-021 out_pc SHALL be in_pc for a halt instruction, otherwise in_pc_plus1.
REQ-022 The register file SHALL hold 8 x DATA_W registers with 2 combinational reads (src1, src2) and 1 synchronous write (wb_en).
REQ-023 With BYPASS=1, a read whose address equals wb_reg while wb_en=1 SHALL return wb_data; with BYPASS=0 it SHALL return the old value.
REQ-024 The stage SHALL hold a single output register; all out_* fields are loaded from decode on accept, so latency is one cycle from input transfer to out_valid.
REQ-025 hazard = out_valid & out_mem_rd & out_wr_en & (out_wr_reg==src1 | out_wr_reg==src2), evaluated on in_inst.
REQ-026 in_ready = !rst & !flush & !halted & !hazard & (!out_valid | out_ready).
REQ-027 On accept, out_valid SHALL be 1 next cycle; else if out_ready, out_valid SHALL be 0; else all out_* SHALL hold.
REQ-028 flush SHALL clear out_valid next cycle and block the accept in that cycle; flush has priority over accept and hold.
REQ-029 The state machine SHALL be RUN -> HALTED when a halt instruction is accepted.
REQ-030 The state machine SHALL be HALTED -> RUN on flush only if out_valid & out_halt (halt squashed); otherwise HALTED is kept until reset.
REQ-031 stall_cnt SHALL increment in every cycle with in_valid & hazard & !flush, saturating at all-ones.
REQ-032 The register-file write SHALL proceed regardless of stall, flush, or halt.

Reset
REQ-033 rst SHALL immediately set state RUN, out_valid 0, all out_* 0, halted 0, stall_cnt 0, and all registers 0.
REQ-034 rst asserted mid-transfer SHALL discard the in-flight instruction; no transfer occurs while rst=1.

Verification
REQ-035 Scenario: after reset, wb writes r3=0x0000_00AA; inst 0xC6C0 (src1=r3, src2=r3) -> next cycle out_valid=1, out_alu_ctrl=0000, out_rd1=out_rd2=0xAA, out_wr_reg=3.
REQ-036 Scenario: load 0x8600 (wr r3) held in the output, then inst 0xC0C8 reading r3 -> in_ready=0 for one cycle, stall_cnt=1, accept the following cycle.
REQ-037 Scenario: out_ready=0 for 3 cycles with out_valid=1 -> all out_* stable and in_ready=0; release -> the next instruction is accepted.
REQ-038 Scenario: halt 0x0000 at in_pc=0x0010 -> out_pc=0x0010, out_halt=1, halted=1, in_ready=0; flush while still in the output -> halted=0 and out_valid=0.
REQ-039 Scenario: BYPASS=1 with wb_en writing r5=0x1234 while decoding a read of r5 -> out_rd 0x1234; BYPASS=0 -> the old value.
REQ-040 Scenario: rst asserted asynchronously mid-cycle with out_valid=1 -> out_valid=0 and stall_cnt=0 immediately, without waiting for a clk edge.
